// File: rtl/hpdcache_mem_read_responder.sv
// HPDcache refill responder: queues line read requests, reads a
// single-port sync RAM one beat at a time and returns response bursts.
module hpdcache_mem_read_responder #(
  parameter int unsigned PA_WIDTH       = 49,
  parameter int unsigned MEM_DATA_WIDTH = 128,
  parameter int unsigned MEM_ID_WIDTH   = 7,
  parameter int unsigned REQ_FIFO_DEPTH = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [PA_WIDTH-1:0]       req_addr_i,
  input  logic [7:0]                req_len_i,
  input  logic [2:0]                req_size_i,
  input  logic [MEM_ID_WIDTH-1:0]   req_id_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [MEM_DATA_WIDTH-1:0] rsp_data_o,
  output logic [MEM_ID_WIDTH-1:0]   rsp_id_o,
  output logic                      rsp_last_o,
  output logic [1:0]                rsp_error_o,
  output logic                      ram_rd_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] ram_rdata_i
);

  localparam int unsigned BEAT_BYTES = MEM_DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(BEAT_BYTES);
  localparam int unsigned PTR_W =
    (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(REQ_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [PA_WIDTH-1:0]     addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [MEM_ID_WIDTH-1:0] id;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  req_t             mem_q [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             push;
  logic             pop;
  req_t             head;
  logic             head_err;
  logic [RAM_ADDR_WIDTH-1:0] head_word;

  state_t                    state_q;
  logic [RAM_ADDR_WIDTH-1:0] base_q;
  logic [7:0]                len_q;
  logic [7:0]                k_q;
  logic                      err_q;
  logic                      fresh_q;
  logic [MEM_DATA_WIDTH-1:0] data_q;
  logic [MEM_DATA_WIDTH-1:0] beat_data;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(REQ_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push  = req_valid_i && req_ready_o;
  assign pop   = (state_q == IDLE) && (cnt_q != '0);
  assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

  assign head      = mem_q[rd_ptr_q];
  assign head_err  = (head.size != 3'(OFF)) ||
                     (head.addr[OFF-1:0] != '0);
  assign head_word = RAM_ADDR_WIDTH'(head.addr >> OFF);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: req_addr_i, len: req_len_i,
                           size: req_size_i, id: req_id_i};
    end
  end

  // Ready comes from next occupancy so it never sees req_valid_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      req_ready_o <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q       <= cnt_d;
      req_ready_o <= (cnt_d != CNT_W'(REQ_FIFO_DEPTH));
    end
  end

  // RAM data only lands in the first HOLD cycle; afterwards it is
  // replayed from data_q so the beat stays stable under backpressure.
  assign beat_data  = err_q ? '0 : ram_rdata_i;
  assign rsp_data_o = fresh_q ? beat_data : data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      fresh_q     <= 1'b0;
      data_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_last_o  <= 1'b0;
      rsp_error_o <= 2'b00;
      ram_rd_o    <= 1'b0;
      ram_addr_o  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            base_q     <= head_word;
            len_q      <= head.len;
            rsp_id_o   <= head.id;
            err_q      <= head_err;
            k_q        <= '0;
            ram_rd_o   <= !head_err;
            ram_addr_o <= head_word;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          ram_rd_o    <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_last_o  <= (k_q == len_q);
          rsp_error_o <= err_q ? 2'b10 : 2'b00;
          fresh_q     <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          fresh_q <= 1'b0;
          if (fresh_q) data_q <= beat_data;
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_last_o  <= 1'b0;
            rsp_error_o <= 2'b00;
            if (rsp_last_o) begin
              state_q <= IDLE;
            end else begin
              k_q        <= k_q + 8'd1;
              ram_rd_o   <= !err_q;
              ram_addr_o <= base_q + RAM_ADDR_WIDTH'(k_q)
                            + RAM_ADDR_WIDTH'(1);
              state_q    <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_read_responder.sv
// Bench for hpdcache_mem_read_responder: directed scenarios plus random
// traffic scored against a transaction-level queue model.
module tb_hpdcache_mem_read_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [48:0]  req_addr = '0;
  logic [7:0]   req_len = '0;
  logic [2:0]   req_size = '0;
  logic [6:0]   req_id = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic [6:0]   rsp_id;
  logic         rsp_last;
  logic [1:0]   rsp_error;
  logic         ram_rd;
  logic [15:0]  ram_addr;
  logic [127:0] ram_rdata = '0;

  hpdcache_mem_read_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_size_i  (req_size),
    .req_id_i    (req_id),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .rsp_last_o  (rsp_last),
    .rsp_error_o (rsp_error),
    .ram_rd_o    (ram_rd),
    .ram_addr_o  (ram_addr),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // Backing RAM: word i holds value i.
  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= 128'(ram_addr);
  end

  typedef struct {
    logic [127:0] data;
    logic [6:0]   id;
    logic         last;
    logic [1:0]   err;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned ra_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int beats_seen = 0;
  int rd_total = 0;
  bit rnd_ready = 0;
  bit last_fire = 0;

  bit           p_hold = 0;
  logic [127:0] p_data;
  logic [6:0]   p_id;
  logic         p_last;
  logic [1:0]   p_err;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(logic [48:0] a, logic [7:0] l,
                            logic [2:0] s, logic [6:0] id);
    bit e;
    logic [15:0] w;
    beat_t bt;
    e = (s != 3'd4) || (a[3:0] != 4'h0);
    for (int b = 0; b <= int'(l); b++) begin
      w = 16'((a >> 4) + 49'(b));
      bt.data = e ? '0 : 128'(w);
      bt.id   = id;
      bt.last = (b == int'(l));
      bt.err  = e ? 2'b10 : 2'b00;
      exp_q.push_back(bt);
      if (!e) ra_q.push_back(int'(w));
    end
  endtask

  task automatic tick();
    bit rf, sf;
    beat_t x;
    if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
    rf = req_valid && req_ready;
    sf = rsp_valid && rsp_ready;
    if (p_hold) begin
      chk("hold_valid", 128'(rsp_valid), 128'(1));
      chk("hold_data", rsp_data, p_data);
      chk("hold_id", 128'(rsp_id), 128'(p_id));
      chk("hold_last", 128'(rsp_last), 128'(p_last));
      chk("hold_err", 128'(rsp_error), 128'(p_err));
    end
    p_hold = rsp_valid && !rsp_ready;
    p_data = rsp_data;
    p_id   = rsp_id;
    p_last = rsp_last;
    p_err  = rsp_error;
    if (sf) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 128'(1), 128'(0));
      end else begin
        x = exp_q.pop_front();
        chk("rsp_data", rsp_data, x.data);
        chk("rsp_id", 128'(rsp_id), 128'(x.id));
        chk("rsp_last", 128'(rsp_last), 128'(x.last));
        chk("rsp_error", 128'(rsp_error), 128'(x.err));
      end
    end
    if (ram_rd) begin
      rd_total++;
      if (ra_q.size() == 0) chk("ram_rd_spurious", 128'(1), 128'(0));
      else chk("ram_addr", 128'(ram_addr), 128'(ra_q.pop_front()));
    end
    if (rf) model_push(req_addr, req_len, req_size, req_id);
    last_fire = rf;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [48:0] a, logic [7:0] l,
                      logic [2:0] s, logic [6:0] id);
    int n;
    req_valid = 1'b1;
    req_addr = a;
    req_len = l;
    req_size = s;
    req_id = id;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 500);
    req_valid = 1'b0;
    chk("req_accepted", 128'(last_fire), 128'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ra_q.size() != 0) && n < 4000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("drain_beats_left", 128'(exp_q.size()), 128'(0));
    chk("drain_reads_left", 128'(ra_q.size()), 128'(0));
  endtask

  initial begin
    int n, b0, r0;
    logic [48:0] a;
    logic [2:0]  s;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 128'(req_ready), 128'(1));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_ram_rd", 128'(ram_rd), 128'(0));
    chk("reset_rsp_data", rsp_data, 128'(0));
    chk("reset_rsp_misc",
        128'({rsp_id, rsp_last, rsp_error, ram_addr}), 128'(0));
    rst_n = 1'b1;
    tick();

    rsp_ready = 1'b1;
    send(49'h1000, 8'd3, 3'd4, 7'd5);
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("first_beat_latency", 128'(n), 128'(2));
    b0 = beats_seen;
    drain();
    chk("basic_beat_count", 128'(beats_seen - b0), 128'(4));

    // Backpressure on beat 1 for five cycles.
    b0 = beats_seen;
    r0 = rd_total;
    send(49'h1000, 8'd3, 3'd4, 7'd5);
    n = 0;
    while (!(rsp_valid && beats_seen - b0 == 1) && n < 50) begin
      tick();
      n++;
    end
    rsp_ready = 1'b0;
    repeat (5) tick();
    rsp_ready = 1'b1;
    drain();
    chk("bp_beat_count", 128'(beats_seen - b0), 128'(4));
    chk("bp_ram_reads", 128'(rd_total - r0), 128'(4));

    // Error bursts: wrong size, then misaligned address.
    r0 = rd_total;
    b0 = beats_seen;
    send(49'h1000, 8'd1, 3'd3, 7'd9);
    drain();
    send(49'h1008, 8'd2, 3'd4, 7'd10);
    drain();
    chk("err_no_ram_rd", 128'(rd_total - r0), 128'(0));
    chk("err_beat_count", 128'(beats_seen - b0), 128'(5));

    // Queue fill behind a stalled burst; duplicate ids allowed.
    rsp_ready = 1'b0;
    send(49'h2000, 8'd0, 3'd4, 7'd1);
    repeat (2) tick();
    send(49'h3000, 8'd1, 3'd4, 7'd2);
    send(49'h4000, 8'd0, 3'd4, 7'd2);
    chk("full_ready_low", 128'(req_ready), 128'(0));
    req_valid = 1'b1;
    req_addr = 49'h5000;
    req_len = 8'd2;
    req_size = 3'd4;
    req_id = 7'd3;
    n = 0;
    repeat (5) begin
      tick();
      if (last_fire) n++;
    end
    chk("full_blocked", 128'(n), 128'(0));
    rsp_ready = 1'b1;
    n = 0;
    while (!last_fire && n < 100) begin
      tick();
      n++;
    end
    req_valid = 1'b0;
    chk("full_third_accepted", 128'(last_fire), 128'(1));
    drain();

    // len 0, address wrap and maximum length.
    b0 = beats_seen;
    send(49'h7770, 8'd0, 3'd4, 7'd11);
    drain();
    chk("len0_beats", 128'(beats_seen - b0), 128'(1));
    r0 = rd_total;
    send(49'hFFFF0, 8'd1, 3'd4, 7'd12);
    drain();
    chk("wrap_reads", 128'(rd_total - r0), 128'(2));
    b0 = beats_seen;
    send(49'h0, 8'd255, 3'd4, 7'd13);
    drain();
    chk("len255_beats", 128'(beats_seen - b0), 128'(256));

    // Reset while beat 2 of a 4-beat burst is presented.
    b0 = beats_seen;
    rsp_ready = 1'b1;
    send(49'h1000, 8'd3, 3'd4, 7'd14);
    n = 0;
    while (!(rsp_valid && beats_seen - b0 == 2) && n < 50) begin
      tick();
      n++;
    end
    chk("rst_reached_beat2", 128'(rsp_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(1));
    exp_q.delete();
    ra_q.delete();
    p_hold = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_beats", 128'(rsp_valid), 128'(0));
    b0 = beats_seen;
    send(49'h1230, 8'd2, 3'd4, 7'd15);
    drain();
    chk("post_rst_beats", 128'(beats_seen - b0), 128'(3));

    // Random traffic with random response backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) a[3:0] = 4'h0;
      s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      repeat ($urandom_range(0, 3)) tick();
      send(a, 8'($urandom_range(0, 7)), s, 7'($urandom));
    end
    drain();
    rnd_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
